// File: rtl/fetch_unit_pkg.sv
// Shared rv32i definitions used by the fetch front end.
//   priv_e         : privilege encodings carried on priv / treqpriv
//   RESET_VECTOR   : default first fetch address after reset
//   fetch_entry_t  : one response-buffer entry {err, pc, data}
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PRIV_U    = 2'b00,
    PRIV_S    = 2'b01,
    PRIV_RSVD = 2'b10,
    PRIV_M    = 2'b11
  } priv_e;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instructions until decode takes them.
//   clk, reset : clock, asynchronous active-low reset
//   clr_i      : synchronous flush (empties the FIFO, wins over push/pop)
//   push_i     : write din_i
//   pop_i      : drop the head entry
//   dout_o     : head entry (meaningful only while count_o != 0)
//   count_o    : occupancy, 0 .. 2**DEPTHX
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTHX = 2,
  parameter int unsigned WIDTH  = ENTRY_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  din_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  dout_o,
  output logic [DEPTHX:0]   count_o
);

  localparam int unsigned DEPTH = 2 ** DEPTHX;
  localparam int unsigned CW    = DEPTHX + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTHX-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTHX:0]   count_q;
  logic              full, do_push, do_pop;

  assign full    = count_q[DEPTHX];
  assign do_pop  = pop_i & (count_q != '0);
  // Upstream credit accounting should never overfill; the guard keeps the
  // FIFO consistent even if it did.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTHX'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTHX'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~clr_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction fetch front end.
//   clk, reset                      : clock, asynchronous active-low reset
//   treqvalid/treqready/treqaddr/
//   treqpriv                        : ROM request port (word-aligned address)
//   trspvalid/trspready/trspdata/
//   trsprerr                        : ROM response port, in-order, 1 per request
//   priv                            : current privilege, copied to treqpriv
//   jump, jump_addr                 : single-cycle redirect and its target
//   ivalid/iready/ins/ipc/ierr      : instruction handed to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned C_FIFO_DEPTHX  = 2,
  parameter logic [31:0] C_RESET_VECTOR = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        treqready,
  output logic        treqvalid,
  output logic [1:0]  treqpriv,
  output logic [31:0] treqaddr,
  output logic        trspready,
  input  logic        trspvalid,
  input  logic        trsprerr,
  input  logic [31:0] trspdata,
  input  logic [1:0]  priv,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        ivalid,
  input  logic        iready,
  output logic [31:0] ins,
  output logic [31:0] ipc,
  output logic        ierr
);

  localparam int unsigned DEPTH = 2 ** C_FIFO_DEPTHX;
  localparam int unsigned CW    = C_FIFO_DEPTHX + 1;
  localparam int unsigned CW1   = CW + 1;

  logic          started_q;
  logic [31:0]   reqpc_q, reqpc_d;
  logic [31:0]   rsppc_q, rsppc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count;
  logic [CW:0]   credit;
  logic [31:0]   jump_tgt;
  logic          req_fire, push, pop;
  fetch_entry_t  push_entry, head;
  logic          unused_jump_lsb;

  assign jump_tgt        = {jump_addr[31:2], 2'b00};
  assign unused_jump_lsb = ^jump_addr[1:0];

  // Every accepted request owns a buffer slot until it is answered or popped,
  // so responses can always be taken and trspready never has to drop.
  assign credit    = {1'b0, outst_q} + {1'b0, count};
  assign treqvalid = started_q & ~jump & (credit < CW1'(DEPTH));
  assign req_fire  = treqvalid & treqready;
  assign treqaddr  = reqpc_q;
  assign treqpriv  = priv;
  assign trspready = started_q;

  always_comb begin
    reqpc_d = reqpc_q;
    if (jump)          reqpc_d = jump_tgt;
    else if (req_fire) reqpc_d = reqpc_q + 32'd4;
  end

  always_comb begin
    outst_d = outst_q;
    if (req_fire & ~trspvalid)      outst_d = outst_q + CW'(1);
    else if (~req_fire & trspvalid) outst_d = outst_q - CW'(1);
  end

  // On a redirect everything still in flight is stale; the response landing
  // in the jump cycle itself is dropped directly, the rest via discard.
  always_comb begin
    push      = 1'b0;
    discard_d = discard_q;
    rsppc_d   = rsppc_q;
    if (jump) begin
      discard_d = trspvalid ? outst_q - CW'(1) : outst_q;
      rsppc_d   = jump_tgt;
    end else if (trspvalid) begin
      if (discard_q == '0) begin
        push    = 1'b1;
        rsppc_d = rsppc_q + 32'd4;
      end else begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q <= 1'b0;
      reqpc_q   <= C_RESET_VECTOR;
      rsppc_q   <= C_RESET_VECTOR;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      started_q <= 1'b1;
      reqpc_q   <= reqpc_d;
      rsppc_q   <= rsppc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  assign push_entry = '{err: trsprerr, pc: rsppc_q, data: trspdata};
  assign pop        = ivalid & iready & ~jump;

  fetch_fifo #(
    .DEPTHX (C_FIFO_DEPTHX),
    .WIDTH  ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (jump),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (count)
  );

  // Outputs show idle values while empty so stale memory never leaks out.
  assign ivalid = (count != '0);
  assign ins    = ivalid ? head.data : 32'h0;
  assign ipc    = ivalid ? head.pc   : C_RESET_VECTOR;
  assign ierr   = ivalid & head.err;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        treqready, treqvalid;
  logic [1:0]  treqpriv, priv;
  logic [31:0] treqaddr;
  logic        trspready, trspvalid, trsprerr;
  logic [31:0] trspdata;
  logic        jump;
  logic [31:0] jump_addr;
  logic        ivalid, iready, ierr;
  logic [31:0] ins, ipc;

  always #5 clk = ~clk;

  fetch_unit #(.C_FIFO_DEPTHX(2), .C_RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset),
    .treqready(treqready), .treqvalid(treqvalid), .treqpriv(treqpriv), .treqaddr(treqaddr),
    .trspready(trspready), .trspvalid(trspvalid), .trsprerr(trsprerr), .trspdata(trspdata),
    .priv(priv), .jump(jump), .jump_addr(jump_addr),
    .ivalid(ivalid), .iready(iready), .ins(ins), .ipc(ipc), .ierr(ierr)
  );

  typedef struct { logic [31:0] addr; int ep; } req_t;
  typedef struct { int cyc; logic [31:0] pc; logic [31:0] ins; logic err; } pop_t;

  req_t        rq[$];        // requests accepted by the ROM, not yet answered
  pop_t        pop_log[$];
  req_t        e;
  int unsigned n_vec = 0, n_err = 0;
  int          cyc = 0, buffered = 0, epoch = 0, n_fire = 0;
  bit          released = 0, started_m = 0, f_jump = 0;
  logic [31:0] exp_pc = RV, exp_req = RV, f_addr = 32'h0;
  int unsigned p_trq = 0, p_ir = 0, p_rsp = 0, p_jmp = 0;
  logic        exp_tv;

  function automatic logic [31:0] rom_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic rom_err(input logic [31:0] a);
    return (a == 32'h8) || (a[8:2] == 7'h2B);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Architectural model: decode must see exp_pc, exp_pc+4, ... restarting at
  // each jump target; the ROM serves requests strictly in order.
  always @(negedge clk) begin
    if (!reset) begin
      chk1("rst_treqvalid", treqvalid, 1'b0);
      chk1("rst_ivalid", ivalid, 1'b0);
      chk1("rst_trspready", trspready, 1'b0);
    end else begin
      chk1("trspready", trspready, started_m);
      chk("treqpriv", {30'b0, treqpriv}, {30'b0, priv});
      exp_tv = started_m && !jump && (rq.size() + buffered < 4);
      chk1("treqvalid", treqvalid, exp_tv);
      if (treqvalid === 1'b1) chk("treqaddr", treqaddr, exp_req);
      chk1("ivalid", ivalid, buffered != 0);
      if (ivalid === 1'b1 && iready && !jump) begin
        chk("ipc", ipc, exp_pc);
        chk("ins", ins, rom_data(exp_pc));
        chk1("ierr", ierr, rom_err(exp_pc));
        pop_log.push_back('{cyc, ipc, ins, ierr});
        exp_pc += 32'd4;
        if (buffered > 0) buffered--;
      end
      if (trspvalid && rq.size() > 0) begin
        e = rq.pop_front();
        if (!jump && e.ep == epoch) buffered++;
      end
      if (treqvalid === 1'b1 && treqready) begin
        rq.push_back('{treqaddr, epoch});
        exp_req += 32'd4;
        n_fire++;
      end
      if (jump) begin
        epoch++;
        buffered = 0;
        exp_req  = {jump_addr[31:2], 2'b00};
        exp_pc   = exp_req;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    started_m = released;
    #1;
    cyc++;
    priv      = 2'($urandom);
    treqready = ($urandom_range(99) < p_trq);
    iready    = ($urandom_range(99) < p_ir);
    jump      = reset && (f_jump || ($urandom_range(99) < p_jmp));
    if (f_jump) jump_addr = f_addr;
    else if ($urandom_range(3) == 0) jump_addr = 32'hFFFF_FFF0 | $urandom_range(15);
    else jump_addr = $urandom;
    f_jump = 0;
    if (reset && rq.size() > 0 && $urandom_range(99) < p_rsp) begin
      trspvalid = 1'b1;
      trspdata  = rom_data(rq[0].addr);
      trsprerr  = rom_err(rq[0].addr);
    end else begin
      trspvalid = 1'b0;
      trspdata  = $urandom;
      trsprerr  = 1'($urandom);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset    = 1'b1;
    released = 1;
    cyc      = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0; released = 0; started_m = 0;
    jump = 1'b0; trspvalid = 1'b0; treqready = 1'b0; iready = 1'b0;
    rq.delete(); buffered = 0; epoch++; exp_pc = RV; exp_req = RV;
    #1;
    chk1("arst_ivalid", ivalid, 1'b0);
    chk1("arst_treqvalid", treqvalid, 1'b0);
    chk1("arst_trspready", trspready, 1'b0);
    chk("arst_ipc", ipc, RV);
    chk("arst_ins", ins, 32'h0);
    repeat (2) cycle();
  endtask

  task automatic wait_pops(input int n, input int bound);
    for (int i = 0; i < bound && pop_log.size() < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b0; treqready = 0; trspvalid = 0; trsprerr = 0; trspdata = 0;
    priv = 0; jump = 0; jump_addr = 0; iready = 0;
    repeat (2) cycle();
    chk("rst_treqaddr", treqaddr, RV);
    chk("rst_ipc", ipc, RV);
    chk("rst_ins", ins, 32'h0);
    chk1("rst_ierr", ierr, 1'b0);

    // Stream from reset with an always-ready ROM, error word at 0x8.
    p_trq = 100; p_ir = 100; p_rsp = 100;
    pop_log.delete();
    release_reset();
    repeat (10) cycle();
    chk1("stream_count", pop_log.size() >= 4, 1'b1);
    if (pop_log.size() >= 4) begin
      chk("stream_first_cycle", pop_log[0].cyc, 3);
      chk("stream_fourth_cycle", pop_log[3].cyc, 6);
      chk("stream_pc0", pop_log[0].pc, 32'h0);
      chk("stream_pc1", pop_log[1].pc, 32'h4);
      chk("stream_pc2", pop_log[2].pc, 32'h8);
      chk("stream_pc3", pop_log[3].pc, 32'hC);
      chk("stream_err", {28'b0, pop_log[0].err, pop_log[1].err, pop_log[2].err, pop_log[3].err},
          32'b0010);
    end

    // Backpressure: exactly four requests, then drain and resume at 0x10.
    do_reset();
    p_trq = 100; p_ir = 0; p_rsp = 100;
    n_fire = 0;
    release_reset();
    repeat (10) cycle();
    chk("bp_requests", n_fire, 4);
    chk1("bp_treqvalid", treqvalid, 1'b0);
    chk("bp_treqaddr", treqaddr, 32'h10);
    pop_log.delete();
    p_ir = 100;
    repeat (10) cycle();
    chk1("bp_drain_count", pop_log.size() >= 5, 1'b1);
    if (pop_log.size() >= 5) begin
      chk("bp_drain_pc0", pop_log[0].pc, 32'h0);
      chk("bp_resume_pc", pop_log[4].pc, 32'h10);
    end

    // Redirect with two buffered entries and one response in flight.
    do_reset();
    p_trq = 100; p_ir = 0; p_rsp = 100;
    release_reset();
    repeat (3) cycle();
    chk1("jmp_setup_ivalid", ivalid, 1'b1);
    chk("jmp_setup_ipc", ipc, 32'h0);
    p_trq = 0; p_rsp = 0; f_jump = 1; f_addr = 32'h100;
    cycle();
    p_trq = 100; p_ir = 100; p_rsp = 100;
    pop_log.delete();
    wait_pops(1, 12);
    chk1("jmp_timeout", pop_log.size() >= 1, 1'b1);
    if (pop_log.size() >= 1) begin
      chk("jmp_first_pc", pop_log[0].pc, 32'h100);
      chk("jmp_first_ins", pop_log[0].ins, rom_data(32'h100));
    end

    // Jump coinciding with a response, unaligned target.
    repeat (3) cycle();
    f_jump = 1; f_addr = 32'h203;
    cycle();
    pop_log.delete();
    cycle();
    chk1("jedge_treqvalid", treqvalid, 1'b1);
    chk("jedge_treqaddr", treqaddr, 32'h200);
    wait_pops(1, 12);
    chk1("jedge_timeout", pop_log.size() >= 1, 1'b1);
    if (pop_log.size() >= 1) chk("jedge_first_pc", pop_log[0].pc, 32'h200);
    pop_log.delete();
    repeat (10) cycle();
    chk1("jedge_throughput", pop_log.size() >= 9, 1'b1);

    // Reset with three buffered entries.
    do_reset();
    p_trq = 100; p_ir = 0; p_rsp = 100;
    release_reset();
    for (int i = 0; i < 20 && buffered < 3; i++) cycle();
    chk1("mrst_setup_ivalid", ivalid, 1'b1);
    do_reset();
    release_reset();
    cycle();
    chk1("mrst_treqvalid", treqvalid, 1'b1);
    chk("mrst_treqaddr", treqaddr, RV);

    // Randomized traffic with jumps, stalls and a mid-run reset.
    p_trq = 75; p_ir = 70; p_rsp = 60; p_jmp = 3;
    repeat (2000) cycle();
    do_reset();
    release_reset();
    repeat (2000) cycle();
    p_ir = 20; p_rsp = 90;
    repeat (1000) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the rv32i core. It generates sequential word-aligned fetch addresses and drives the instruction request port of the boot/instruction ROM. It collects the in-order responses in a small credit-managed buffer and presents them, with their PC, to decode through a valid/ready handshake. On a redirect (jump) it flushes the buffer and drops every stale in-flight response.

## Interface
- C_FIFO_DEPTHX, 2 — log2 of the response buffer depth (depth = 2**C_FIFO_DEPTHX = 4)
- C_RESET_VECTOR, 32'h0000_0000 — first fetch address after reset; bits [1:0] must be 0
- clk  in  1  — clock; all state on rising edge
- reset  in  1  — asynchronous, active-low reset
- treqready  in  1  — ROM accepts the request this cycle
- treqvalid  out  1  — fetch request valid
- treqpriv  out  2  — privilege of the request (copy of priv)
- treqaddr  out  32  — fetch address, always word aligned
- trspready  out  1  — response accept; constant 1 after reset
- trspvalid  in  1  — response valid; the ROM returns responses in order, one per accepted request
- trsprerr  in  1  — response bus error
- trspdata  in  32  — instruction word
- priv  in  2  — current privilege level
- jump  in  1  — redirect strobe, single-cycle qualifier
- jump_addr  in  32  — redirect target; bits [1:0] are forced to 0
- ivalid  out  1  — instruction available to decode
- iready  in  1  — decode consumes the instruction
- ins  out  32  — instruction word
- ipc  out  32  — PC of ins
- ierr  out  1  — fetch error attached to ins

## Operation
- **reqpc register:** drives treqaddr. On the cycle treqvalid & treqready, reqpc <= reqpc + 4, wrapping modulo 2**32. On jump, reqpc <= {jump_addr[31:2],2'b00}.
- **Request gating:** treqvalid = started & ~jump & (outstanding + count < DEPTH).
  - started: a flag that sets on the first clk edge after reset release.
  - outstanding: requests accepted but not yet answered, C_FIFO_DEPTHX+1 bits.
  - count: buffer occupancy.
  - This credit rule guarantees buffer space for every response, so trspready is held at 1.
- **outstanding update:** +1 on request accept, −1 on trspvalid, both in the same cycle leaves it unchanged.
- **Response path:** if discard == 0, push {trsprerr, rsppc, trspdata} into the buffer and set rsppc <= rsppc + 4. Otherwise drop the response and decrement discard.
- **Decode handshake:** ivalid = (count != 0). The head entry drives ins/ipc/ierr. An entry is popped on ivalid & iready. Push and pop in the same cycle leave count unchanged.
- **Jump cycle**, taking effect at the edge:
  - buffer cleared (count <= 0);
  - a response arriving in this cycle is dropped;
  - discard <= outstanding − trspvalid;
  - rsppc <= target;
  - a pop in the jump cycle is ignored;
  - no request is issued in the jump cycle.
- **Jump while discard != 0:** discard is reloaded using the same rule.
- **Errors:** trsprerr is passed through as ierr. Fetching continues; stopping fetch is the decoder's responsibility.

## Timing
- Reset values: treqvalid 0, treqaddr = C_RESET_VECTOR, treqpriv = priv (combinational), trspready 0 in reset and 1 from the first edge after release, ivalid 0, ins 32'h0, ipc = C_RESET_VECTOR, ierr 0.
- Internal reset values: started 0, outstanding 0, discard 0, count 0, rsppc = C_RESET_VECTOR.
- First request: treqvalid rises in the first cycle after the first edge following reset release.
- Latency against the 1-cycle ROM:
  - request accepted at edge N;
  - trspvalid high during cycle N..N+1;
  - written at edge N+1;
  - ivalid high after edge N+1.
  - No buffer bypass.
- Throughput: 1 instruction per cycle with iready held high.
- Full case: outstanding + count == 4 forces treqvalid low the same cycle, with no overshoot.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight responses are not tracked.

## Structure
- The shared rv32i package holds the privilege encodings (treqpriv/priv) and the default reset vector constant.
- Sub-module fetch_fifo: a synchronous FIFO, width 65 ({err, pc, data}), depth 2**C_FIFO_DEPTHX, with a synchronous clear input for the flush.
- Counters, reqpc/rsppc, and the discard logic stay in fetch_unit.

## Test plan
- **Reset/stream:** release reset with iready=1 and the ROM always ready → ipc sequence 0x0, 0x4, 0x8…, ins = ROM words, one per cycle after a 2-cycle start.
- **Backpressure:** iready=0 → exactly 4 requests issued, then treqvalid stays 0. Raise iready → the 4 entries drain in order and fetching resumes at 0x10.
- **Redirect with in-flight data:** jump to 0x100 while 1 response is outstanding and 2 entries are buffered → stale data is never shown; the next ivalid carries ipc=0x100.
- **Jump edge cases:** jump in the same cycle as trspvalid, and a jump_addr of 0x203 → the response is dropped, treqaddr = 0x200, discard returns to 0.
- **Error:** ROM returns trsprerr=1 for 0x8 → that entry has ierr=1 and the 0x4/0xC entries have ierr=0.
- **Reset mid-stream:** assert reset with 3 entries buffered → ivalid=0 immediately; after release, fetch restarts at C_RESET_VECTOR.
